// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 24;
    localparam int SRAM_DATA_W = 8;
    localparam int STALL_W     = 16;

    // Which requester, if any, owns the SRAM read data arriving this cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_SPI  = 2'd1,
        RD_CPU  = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/rdata_hold.sv
// rtl/rdata_hold.sv - per-requester read data hold register with bypass
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : SRAM read data this cycle belongs to this requester
//   ram_rdata  : SRAM read data
//   rdata      : requester read data (live SRAM data while capturing, else held)
module rdata_hold
    import sram_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic [SRAM_DATA_W-1:0] ram_rdata,
    output logic [SRAM_DATA_W-1:0] rdata
);

    logic [SRAM_DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= ram_rdata;
        end
    end

    // Bypass gives one-cycle read latency; the register keeps it stable afterwards.
    assign rdata = capture ? ram_rdata : hold_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fixed-priority SPI/CPU arbiter for one synchronous SRAM port
//   CPU_BASE                          : SRAM byte offset of the CPU 64 KiB window
//   clk, rst_n                        : clock, asynchronous active-low reset
//   spi_addr/en/wr/wdata, spi_rdata   : SPI requester (pulse request, highest priority)
//   cpu_addr/en/we/wdata, cpu_gnt,
//   cpu_rdata                         : CPU requester (level request held until granted)
//   ram_addr/en/we/wdata, ram_rdata   : SRAM port, read data one cycle after ram_en
//   stall_cnt, stall_clr              : saturating CPU denial counter and its clear
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [SRAM_ADDR_W-1:0] CPU_BASE = 24'h000000
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [SRAM_ADDR_W-1:0] spi_addr,
    input  logic                   spi_en,
    input  logic                   spi_wr,
    input  logic [SRAM_DATA_W-1:0] spi_wdata,
    output logic [SRAM_DATA_W-1:0] spi_rdata,

    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_en,
    input  logic                   cpu_we,
    input  logic [SRAM_DATA_W-1:0] cpu_wdata,
    output logic                   cpu_gnt,
    output logic [SRAM_DATA_W-1:0] cpu_rdata,

    output logic [SRAM_ADDR_W-1:0] ram_addr,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [SRAM_DATA_W-1:0] ram_wdata,
    input  logic [SRAM_DATA_W-1:0] ram_rdata,

    output logic [STALL_W-1:0]     stall_cnt,
    input  logic                   stall_clr
);

    rd_owner_e              rd_owner_q;
    rd_owner_e              rd_owner_d;
    logic [SRAM_ADDR_W-1:0] cpu_ram_addr;

    // Window offset wraps modulo the SRAM address space.
    assign cpu_ram_addr = CPU_BASE + SRAM_ADDR_W'(cpu_addr);
    assign cpu_gnt      = cpu_en & ~spi_en;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (spi_en) begin
            ram_en    = 1'b1;
            ram_we    = spi_wr;
            ram_addr  = spi_addr;
            ram_wdata = spi_wdata;
        end else if (cpu_en) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_ram_addr;
            ram_wdata = cpu_wdata;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (spi_en && !spi_wr) begin
            rd_owner_d = RD_SPI;
        end else if (cpu_gnt && !cpu_we) begin
            rd_owner_d = RD_CPU;
        end
    end

    // Async reset drops any read in flight so nothing is captured after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q <= RD_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (cpu_en && spi_en && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    rdata_hold u_spi_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (rd_owner_q == RD_SPI),
        .ram_rdata (ram_rdata),
        .rdata     (spi_rdata)
    );

    rdata_hold u_cpu_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (rd_owner_q == RD_CPU),
        .ram_rdata (ram_rdata),
        .rdata     (cpu_rdata)
    );

endmodule
